// File: rtl/if_stage_pkg.sv
// Shared CPU definitions for the instruction-fetch stage: FSM encoding,
// architectural constants and the IF/ID payload layout.
package if_stage_pkg;

    typedef logic [1:0] fsm_state_t;

    localparam fsm_state_t ST_FETCH = 2'd0;
    localparam fsm_state_t ST_HOLD  = 2'd1;
    localparam fsm_state_t ST_DROP  = 2'd2;

    localparam logic [31:0] CPU_NOP_INSTR  = 32'h0000_0000;
    localparam logic [31:0] CPU_EXC_VECTOR = 32'h0000_0180;
    localparam logic [31:0] CPU_RESET_PC   = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } fetch_pkt_t;

endpackage

// File: rtl/if_stage_next_pc_sel.sv
// Redirect priority mux (exception > jump > branch) and the PC+4 adder.
module next_pc_sel #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
) (
    input  logic [31:0] pc,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        exception,
    output logic        redirect,
    output logic [31:0] redirect_target,
    output logic [31:0] pc_plus4
);

    always_comb begin
        redirect        = exception | jump | branch_taken;
        redirect_target = branch_target;
        if (exception) begin
            redirect_target = EXC_VECTOR;
        end else if (jump) begin
            redirect_target = jump_target;
        end
        pc_plus4 = pc + 32'd4;
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: drives the imem request, computes new_pc for the
// PC register and owns the IF/ID pipeline register plus the stall hold buffer.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = CPU_RESET_PC,
    parameter logic [31:0] EXC_VECTOR = CPU_EXC_VECTOR,
    parameter logic [31:0] NOP_INSTR  = CPU_NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic [31:0] new_pc,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        exception,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid
);

    fsm_state_t  state_q, state_d;
    fetch_pkt_t  if_id_q, if_id_d;
    logic        valid_q, valid_d;
    fetch_pkt_t  hold_q, hold_d;
    logic [31:0] drop_addr_q, drop_addr_d;

    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] pc_plus4;

    next_pc_sel #(
        .EXC_VECTOR(EXC_VECTOR)
    ) u_next_pc_sel (
        .pc             (pc),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .jump           (jump),
        .jump_target    (jump_target),
        .exception      (exception),
        .redirect       (redirect),
        .redirect_target(redirect_target),
        .pc_plus4       (pc_plus4)
    );

    always_comb begin
        state_d     = state_q;
        if_id_d     = if_id_q;
        valid_d     = valid_q;
        hold_d      = hold_q;
        drop_addr_d = drop_addr_q;
        imem_req    = 1'b0;
        imem_addr   = pc;
        new_pc      = pc;

        case (state_q)
            ST_FETCH: begin
                imem_req = 1'b1;
                if (redirect) begin
                    new_pc = redirect_target;
                    // Request already in flight must still be retired at its original address.
                    if (!imem_ready) begin
                        drop_addr_d = pc;
                        state_d     = ST_DROP;
                    end
                end else if (imem_ready) begin
                    new_pc = pc_plus4;
                    if (stall) begin
                        hold_d  = '{instr: imem_rdata, pc4: pc_plus4};
                        state_d = ST_HOLD;
                    end else begin
                        if_id_d = '{instr: imem_rdata, pc4: pc_plus4};
                        valid_d = 1'b1;
                    end
                end else if (!stall) begin
                    valid_d = 1'b0;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    new_pc  = redirect_target;
                    state_d = ST_FETCH;
                end else if (!stall) begin
                    if_id_d = hold_q;
                    valid_d = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_DROP: begin
                imem_req  = 1'b1;
                imem_addr = drop_addr_q;
                valid_d   = 1'b0;
                if (redirect) begin
                    new_pc = redirect_target;
                end
                if (imem_ready) begin
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        if (redirect) begin
            valid_d       = 1'b0;
            if_id_d.instr = NOP_INSTR;
            hold_d        = '0;
        end

        if (!reset) begin
            new_pc   = RESET_PC;
            imem_req = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_FETCH;
            if_id_q     <= '{instr: NOP_INSTR, pc4: 32'h0};
            valid_q     <= 1'b0;
            hold_q      <= '0;
            drop_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            if_id_q     <= if_id_d;
            valid_q     <= valid_d;
            hold_q      <= hold_d;
            drop_addr_q <= drop_addr_d;
        end
    end

    assign if_id_instr = if_id_q.instr;
    assign if_id_pc4   = if_id_q.pc4;
    assign if_id_valid = valid_q;

endmodule
